// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: reads the PC register Q, fetches over a req/ack
// memory handshake, hands the instruction to decode over valid/ready, and
// drives the PC register D/Wen for sequential and redirected flow.
// A misaligned PC or a memory that never answers sets a sticky fault.
module instr_fetch_unit #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        C,
    input  logic        CLR,
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc_next,
    output logic        pc_wen,
    output logic        fetch_fault
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      instr_n, instr_pc_n, pc_next_n;
    logic             valid_n, wen_n, fault_n;
    logic             aligned;
    logic             timed_out;

    assign aligned   = (pc[1:0] == 2'b00);
    assign timed_out = (cnt >= TMO);
    assign imem_addr = pc;
    // ISSUE only requests for an aligned PC; WAIT/DRAIN keep the request up
    // until the (fresh or stale) response arrives.
    assign imem_req  = (state == S_ISSUE && aligned) || (state == S_WAIT) ||
                       (state == S_DRAIN);

    // State register.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) state <= S_IDLE;
        else     state <= state_n;
    end

    // Next state and next register values; priority misalign > redirect > ack > timeout.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        instr_n    = instr;
        instr_pc_n = instr_pc;
        valid_n    = instr_valid;
        pc_next_n  = pc_next;
        wen_n      = 1'b0;
        fault_n    = fetch_fault;
        case (state)
            S_IDLE: state_n = S_ISSUE;
            S_ISSUE, S_WAIT: begin
                if (state == S_ISSUE && !aligned) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                end else if (redirect) begin
                    wen_n     = 1'b1;
                    pc_next_n = redirect_pc;
                    if (imem_ack) begin
                        state_n = S_ISSUE;
                    end else begin
                        state_n = S_DRAIN;
                        cnt_n   = CNT_W'(1);
                    end
                end else if (imem_ack) begin
                    instr_n    = imem_rdata;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    wen_n      = 1'b1;
                    pc_next_n  = pc + 32'd4;
                    state_n    = S_HOLD;
                end else if (state == S_ISSUE) begin
                    cnt_n   = CNT_W'(1);
                    state_n = S_WAIT;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                // A response here belongs to the abandoned fetch and is dropped.
                if (redirect) begin
                    wen_n     = 1'b1;
                    pc_next_n = redirect_pc;
                    if (imem_ack) state_n = S_ISSUE;
                end else if (imem_ack) begin
                    state_n = S_ISSUE;
                end else if (timed_out) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    valid_n   = 1'b0;
                    wen_n     = 1'b1;
                    pc_next_n = redirect_pc;
                    state_n   = S_ISSUE;
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    state_n = S_ISSUE;
                end
            end
            S_FAULT: begin
                valid_n = 1'b0;
                fault_n = 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Registered outputs and timeout counter.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            cnt         <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pc_next     <= '0;
            pc_wen      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            cnt         <= cnt_n;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            instr_valid <= valid_n;
            pc_next     <= pc_next_n;
            pc_wen      <= wen_n;
            fetch_fault <= fault_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model that also plays the PC register.
module tb_instr_fetch_unit;

    localparam int TMO = 15;

    logic        C = 1'b0;
    logic        CLR = 1'b1;
    logic [31:0] pc = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc_next;
    logic        pc_wen;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fetch_unit #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .C(C), .CLR(CLR), .pc(pc), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc_next(pc_next),
        .pc_wen(pc_wen), .fetch_fault(fetch_fault)
    );

    always #5 C = ~C;

    // Model: started = first cycle after reset consumed; infl = 0 none,
    // 1 fetch outstanding, 2 abandoned fetch outstanding; age = cycles waited.
    bit          m_started, m_fault, m_hold, m_wen;
    int          m_infl, m_age;
    logic [31:0] m_instr, m_ipc, m_pcn;

    task automatic model_reset();
        m_started = 0; m_fault = 0; m_hold = 0; m_wen = 0;
        m_infl = 0; m_age = 0;
        m_instr = '0; m_ipc = '0; m_pcn = '0;
    endtask

    function automatic bit model_req();
        return m_started && !m_fault && !m_hold && (m_infl != 0 || pc[1:0] == 2'b00);
    endfunction

    task automatic assert_reset();
        CLR = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge C); #1;
        CLR = 1'b0;
        #1;
    endtask

    // One clock: model decides from the inputs seen at the edge, PC register
    // takes pc_next if a write was pending.
    task automatic tick();
        bit          s, f, h, w;
        int          inf, age;
        logic [31:0] ins, ipc, pcn;
        s = m_started; f = m_fault; h = m_hold; w = 0;
        inf = m_infl; age = m_age; ins = m_instr; ipc = m_ipc; pcn = m_pcn;
        if (!m_started) s = 1;
        else if (m_fault) h = 0;
        else if (m_hold) begin
            if (redirect) begin h = 0; w = 1; pcn = redirect_pc; end
            else if (instr_ready) h = 0;
        end else if (m_infl == 0 && pc[1:0] != 2'b00) f = 1;
        else if (redirect) begin
            w = 1; pcn = redirect_pc;
            if (imem_ack) inf = 0;
            else if (m_infl != 2) begin inf = 2; age = 1; end
        end else if (imem_ack) begin
            if (m_infl == 2) inf = 0;
            else begin ins = imem_rdata; ipc = pc; h = 1; w = 1; pcn = pc + 32'd4; inf = 0; end
        end else if (m_infl == 0) begin inf = 1; age = 1; end
        else if (m_age >= TMO) f = 1;
        else age = m_age + 1;
        @(posedge C); #1;
        if (m_wen) pc = m_pcn;
        m_started = s; m_fault = f; m_hold = h; m_wen = w;
        m_infl = inf; m_age = age; m_instr = ins; m_ipc = ipc; m_pcn = pcn;
        #1;
    endtask

    task automatic test_reset();
        assert_reset();
        n_checks++; if (instr !== 32'h0) $display("FAIL rst_instr got %h want 0", instr); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0) $display("FAIL rst_instr_pc got %h want 0", instr_pc); else n_pass++;
        n_checks++; if (pc_next !== 32'h0) $display("FAIL rst_pc_next got %h want 0", pc_next); else n_pass++;
        n_checks++; if ({instr_valid, pc_wen, fetch_fault} !== 3'b000)
            $display("FAIL rst_flags got %b want 000", {instr_valid, pc_wen, fetch_fault}); else n_pass++;
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
    endtask

    task automatic test_zero_wait();
        assert_reset();
        pc = 32'h0040_0000; imem_rdata = 32'hDEAD_BEEF; imem_ack = 1; instr_ready = 1; redirect = 0;
        release_reset();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL zw_idle_req got %b want 0", imem_req); else n_pass++;
        tick();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL zw_issue_req got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0040_0000) $display("FAIL zw_addr got %h want 00400000", imem_addr); else n_pass++;
        tick();
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL zw_valid got %b want 1", instr_valid); else n_pass++;
        n_checks++; if (instr !== 32'hDEAD_BEEF) $display("FAIL zw_instr got %h want deadbeef", instr); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0040_0000) $display("FAIL zw_instr_pc got %h want 00400000", instr_pc); else n_pass++;
        n_checks++; if (pc_wen !== 1'b1) $display("FAIL zw_wen got %b want 1", pc_wen); else n_pass++;
        n_checks++; if (pc_next !== 32'h0040_0004) $display("FAIL zw_pc_next got %h want 00400004", pc_next); else n_pass++;
        imem_ack = 0;
        tick();
        n_checks++; if ({instr_valid, pc_wen} !== 2'b00) $display("FAIL zw_after got %b want 00", {instr_valid, pc_wen}); else n_pass++;
        n_checks++; if (pc_next !== 32'h0040_0004) $display("FAIL zw_pc_next_hold got %h want 00400004", pc_next); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0040_0004) $display("FAIL zw_next_addr got %h want 00400004", imem_addr); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL zw_next_req got %b want 1", imem_req); else n_pass++;
    endtask

    task automatic test_backpressure();
        imem_ack = 1; imem_rdata = 32'h1234_5678; instr_ready = 0;
        tick();
        imem_ack = 0;
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", instr_valid); else n_pass++;
        n_checks++; if (pc_next !== 32'h0040_0008) $display("FAIL bp_pc_next got %h want 00400008", pc_next); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h1234_5678)
                $display("FAIL bp_hold[%0d] got %b/%h want 1/12345678", i, instr_valid, instr); else n_pass++;
            n_checks++; if (pc_wen !== 1'b0 || imem_req !== 1'b0)
                $display("FAIL bp_quiet[%0d] got wen=%b req=%b want 0/0", i, pc_wen, imem_req); else n_pass++;
        end
        instr_ready = 1;
        tick();
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL bp_release got %b want 0", instr_valid); else n_pass++;
    endtask

    task automatic test_redirect_wait();
        assert_reset();
        pc = 32'h0040_0000; imem_ack = 0; instr_ready = 0; redirect = 0;
        release_reset();
        tick(); tick();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rd_wait_req got %b want 1", imem_req); else n_pass++;
        redirect = 1; redirect_pc = 32'h0040_0100;
        tick();
        redirect = 0;
        n_checks++; if (pc_wen !== 1'b1 || pc_next !== 32'h0040_0100)
            $display("FAIL rd_wen got %b/%h want 1/00400100", pc_wen, pc_next); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (pc_wen !== 1'b0 || imem_req !== 1'b1)
                $display("FAIL rd_drain[%0d] got wen=%b req=%b want 0/1", i, pc_wen, imem_req); else n_pass++;
        end
        imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || pc_wen !== 1'b0)
            $display("FAIL rd_stale got valid=%b wen=%b want 0/0", instr_valid, pc_wen); else n_pass++;
        n_checks++; if (imem_addr !== 32'h0040_0100) $display("FAIL rd_new_addr got %h want 00400100", imem_addr); else n_pass++;
        imem_rdata = 32'h600D_600D;
        tick();
        imem_ack = 0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 32'h600D_600D)
            $display("FAIL rd_fetch got %b/%h want 1/600d600d", instr_valid, instr); else n_pass++;
        n_checks++; if (instr_pc !== 32'h0040_0100 || pc_next !== 32'h0040_0104)
            $display("FAIL rd_fetch_pc got %h/%h want 00400100/00400104", instr_pc, pc_next); else n_pass++;
    endtask

    task automatic test_timeout();
        assert_reset();
        pc = 32'h0040_0000; imem_ack = 0; instr_ready = 0; redirect = 0;
        release_reset();
        tick(); tick();
        for (int i = 1; i < TMO; i++) begin
            tick();
            n_checks++; if (fetch_fault !== 1'b0 || imem_req !== 1'b1)
                $display("FAIL to_wait[%0d] got fault=%b req=%b want 0/1", i, fetch_fault, imem_req); else n_pass++;
        end
        tick();
        n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0)
            $display("FAIL to_fault got fault=%b req=%b want 1/0", fetch_fault, imem_req); else n_pass++;
        imem_ack = 1; imem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({fetch_fault, instr_valid, pc_wen} !== 3'b100)
                $display("FAIL to_sticky[%0d] got %b want 100", i, {fetch_fault, instr_valid, pc_wen}); else n_pass++;
        end
        imem_ack = 0;
        #2;
        assert_reset();
        n_checks++; if (fetch_fault !== 1'b0) $display("FAIL to_clr got %b want 0", fetch_fault); else n_pass++;
        release_reset();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL to_idle_req got %b want 0", imem_req); else n_pass++;
        tick();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL to_resume_req got %b want 1", imem_req); else n_pass++;
    endtask

    task automatic test_misaligned();
        assert_reset();
        pc = 32'h0040_0002; imem_ack = 1; imem_rdata = 32'h0BAD_F00D; redirect = 0; instr_ready = 0;
        release_reset();
        tick();
        n_checks++; if (imem_req !== 1'b0 || fetch_fault !== 1'b0)
            $display("FAIL mis_issue got req=%b fault=%b want 0/0", imem_req, fetch_fault); else n_pass++;
        tick();
        n_checks++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0)
            $display("FAIL mis_fault got fault=%b req=%b valid=%b want 1/0/0", fetch_fault, imem_req, instr_valid); else n_pass++;
        imem_ack = 0;
    endtask

    task automatic test_wrap_and_async_reset();
        assert_reset();
        pc = 32'hFFFF_FFFC; imem_ack = 1; imem_rdata = $urandom | 32'h1; instr_ready = 0; redirect = 0;
        release_reset();
        tick(); tick();
        n_checks++; if (pc_next !== 32'h0 || pc_wen !== 1'b1)
            $display("FAIL wrap_pc_next got %h/%b want 00000000/1", pc_next, pc_wen); else n_pass++;
        n_checks++; if (instr_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_instr_pc got %h want fffffffc", instr_pc); else n_pass++;
        imem_ack = 0; instr_ready = 1;
        tick(); tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL wrap_wait got req=%b addr=%h want 1/00000000", imem_req, imem_addr); else n_pass++;
        #2;
        assert_reset();
        n_checks++; if (instr !== 32'h0 || instr_pc !== 32'h0 || pc_next !== 32'h0)
            $display("FAIL async_data got %h/%h/%h want 0/0/0", instr, instr_pc, pc_next); else n_pass++;
        n_checks++; if ({instr_valid, pc_wen, fetch_fault, imem_req} !== 4'b0000)
            $display("FAIL async_flags got %b want 0000", {instr_valid, pc_wen, fetch_fault, imem_req}); else n_pass++;
        release_reset();
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 4; ep++) begin
            assert_reset();
            pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            redirect = 0; imem_ack = 0; instr_ready = 0;
            release_reset();
            for (int cyc = 0; cyc < 150; cyc++) begin
                redirect    = ($urandom_range(0, 3) == 0);
                redirect_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                if ($urandom_range(0, 63) == 0) redirect_pc[1:0] = 2'b10;
                imem_ack    = $urandom_range(0, 1);
                imem_rdata  = $urandom;
                instr_ready = $urandom_range(0, 1);
                tick();
                n_checks++; if (instr_valid !== m_hold) $display("FAIL rnd_valid[%0d.%0d] got %b want %b", ep, cyc, instr_valid, m_hold); else n_pass++;
                n_checks++; if (m_hold && (instr !== m_instr || instr_pc !== m_ipc))
                    $display("FAIL rnd_instr[%0d.%0d] got %h@%h want %h@%h", ep, cyc, instr, instr_pc, m_instr, m_ipc); else n_pass++;
                n_checks++; if (pc_wen !== m_wen) $display("FAIL rnd_wen[%0d.%0d] got %b want %b", ep, cyc, pc_wen, m_wen); else n_pass++;
                n_checks++; if (pc_next !== m_pcn) $display("FAIL rnd_pc_next[%0d.%0d] got %h want %h", ep, cyc, pc_next, m_pcn); else n_pass++;
                n_checks++; if (fetch_fault !== m_fault) $display("FAIL rnd_fault[%0d.%0d] got %b want %b", ep, cyc, fetch_fault, m_fault); else n_pass++;
                n_checks++; if (imem_req !== model_req()) $display("FAIL rnd_req[%0d.%0d] got %b want %b", ep, cyc, imem_req, model_req()); else n_pass++;
                n_checks++; if (imem_addr !== pc) $display("FAIL rnd_addr[%0d.%0d] got %h want %h", ep, cyc, imem_addr, pc); else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_timeout();
        test_misaligned();
        test_wrap_and_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
